// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the front end.
//   FETCH_WIDTH  - instructions fetched and delivered per cycle (one pair).
//   fetch_pkt_t  - one fetched pair: both instructions plus their PCs.
//   align_pc     - clears the low two bits of a byte address.
package core_pkg;

  localparam int FETCH_WIDTH = 2;

  // Byte distance between consecutive instructions and between fetch pairs.
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] PAIR_BYTES  = 32'd8;

  typedef struct packed {
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic [31:0] pc0;
    logic [31:0] pc1;
  } fetch_pkt_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_pkt_t.
//   clk, reset  - clock; asynchronous active-high reset.
//   push, push_data - enqueue one pair (accepted when not full, or when full
//                 and popping in the same cycle).
//   pop         - dequeue the head (ignored when empty).
//   flush       - empties the queue; wins over push and pop.
//   head        - current head entry (undefined content when count == 0).
//   count       - number of valid entries, 0..DEPTH.
// DEPTH must be a power of two, at least 2, so pointers wrap by overflow.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_pkt_t    push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_pkt_t    head,
  output logic [CW-1:0] count
);

  fetch_pkt_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // When full, a push is only taken alongside a pop: the slot being written
  // is the head slot, whose old content is read out this same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; count gates whether any entry is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end issuing one aligned pair per cycle.
//   clk, reset        - clock; asynchronous active-high reset.
//   imem_ren          - fetch request; imem_addr0/imem_addr1 = pc / pc+4.
//   imem_valid        - response strobe, one cycle after an accepted request,
//                       with imem_rdata0/1 and imem_pc[0]/[1].
//   redirect_valid/pc - branch/exception redirect; flushes and restarts fetch.
//   dec_valid/ready   - handshake to decode: the head pair (dec_instr0/1,
//                       dec_pc0/1) is consumed in a cycle where both are high.
//                       dec_valid never depends on dec_ready; once high it
//                       stays high with stable data until consumed, unless a
//                       redirect or reset flushes the queue.
// Credit rule: a request is issued only if queued + in-flight pairs leave a
// free slot, so the memory (which cannot stall) always has room to land.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_ren,
  output logic [31:0]                 imem_addr0,
  output logic [31:0]                 imem_addr1,
  input  logic                        imem_valid,
  input  logic [31:0]                 imem_rdata0,
  input  logic [31:0]                 imem_rdata1,
  input  logic [FETCH_WIDTH-1:0][31:0] imem_pc,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        dec_valid,
  output logic [31:0]                 dec_instr0,
  output logic [31:0]                 dec_instr1,
  output logic [31:0]                 dec_pc0,
  output logic [31:0]                 dec_pc1,
  input  logic                        dec_ready
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] fq_count;
  logic [CW:0]   used_slots;
  logic          fq_push;
  logic          fq_pop;
  fetch_pkt_t    push_pkt;
  fetch_pkt_t    head_pkt;

  // Extra bit so count + inflight cannot overflow when the queue is full.
  assign used_slots = {1'b0, fq_count} + (CW + 1)'(inflight_q);

  // reset gates the request so nothing is issued while reset is held.
  assign imem_ren   = ~reset & ~redirect_valid & (used_slots < (CW + 1)'(FQ_DEPTH));
  assign imem_addr0 = pc_q;
  assign imem_addr1 = pc_q + INSTR_BYTES;

  // A response only counts when we actually have a request outstanding, and
  // a redirect discards anything returning in its own cycle.
  assign fq_push = imem_valid & inflight_q & ~redirect_valid;
  assign fq_pop  = dec_valid & dec_ready & ~redirect_valid;

  always_comb begin
    push_pkt        = '0;
    push_pkt.instr0 = imem_rdata0;
    push_pkt.instr1 = imem_rdata1;
    push_pkt.pc0    = imem_pc[0];
    push_pkt.pc1    = imem_pc[1];
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = imem_ren;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (imem_ren) begin
      pc_d = pc_q + PAIR_BYTES;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (fq_push),
    .push_data (push_pkt),
    .pop       (fq_pop),
    .flush     (redirect_valid),
    .head      (head_pkt),
    .count     (fq_count)
  );

  assign dec_valid  = (fq_count != '0);
  assign dec_instr0 = head_pkt.instr0;
  assign dec_instr1 = head_pkt.instr1;
  assign dec_pc0    = head_pkt.pc0;
  assign dec_pc1    = head_pkt.pc1;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a one-cycle-latency
// instruction memory model. Instruction words are a fixed function of their
// address so every delivered pair can be checked against its PC.
module tb_fetch_unit;
  import core_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        imem_ren;
  logic [31:0] imem_addr0, imem_addr1;
  logic        imem_valid;
  logic [31:0] imem_rdata0, imem_rdata1;
  logic [1:0][31:0] imem_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        dec_valid;
  logic [31:0] dec_instr0, dec_instr1, dec_pc0, dec_pc1;
  logic        dec_ready = 1'b0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_ren       (imem_ren),
    .imem_addr0     (imem_addr0),
    .imem_addr1     (imem_addr1),
    .imem_valid     (imem_valid),
    .imem_rdata0    (imem_rdata0),
    .imem_rdata1    (imem_rdata1),
    .imem_pc        (imem_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_instr0     (dec_instr0),
    .dec_instr1     (dec_instr1),
    .dec_pc0        (dec_pc0),
    .dec_pc1        (dec_pc1),
    .dec_ready      (dec_ready)
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  logic        mem_valid = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic        force_valid = 1'b0;        // injects an unsolicited response
  localparam logic [31:0] STALE_PC = 32'hDEAD_0000;

  always @(posedge clk) begin
    mem_valid <= imem_ren;
    mem_a     <= imem_addr0;
  end

  always_comb begin
    if (force_valid) begin
      imem_valid  = 1'b1;
      imem_rdata0 = instr_of(STALE_PC);
      imem_rdata1 = instr_of(STALE_PC + 32'd4);
      imem_pc[0]  = STALE_PC;
      imem_pc[1]  = STALE_PC + 32'd4;
    end else begin
      imem_valid  = mem_valid;
      imem_rdata0 = instr_of(mem_a);
      imem_rdata1 = instr_of(mem_a + 32'd4);
      imem_pc[0]  = mem_a;
      imem_pc[1]  = mem_a + 32'd4;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, " dec_pc0"}, dec_pc0, pc);
    check({tag, " dec_pc1"}, dec_pc1, pc + 32'd4);
    check({tag, " dec_instr0"}, dec_instr0, instr_of(pc));
    check({tag, " dec_instr1"}, dec_instr1, instr_of(pc + 32'd4));
  endtask

  // ---------------- driver tasks ----------------
  // Leaves reset low at a falling edge: the current low phase is the first
  // cycle after release.
  task automatic do_reset();
    reset = 1'b1;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    force_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset imem_ren", {31'b0, imem_ren}, 32'd0);
    check("reset dec_valid", {31'b0, dec_valid}, 32'd0);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        dec_ready;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic        exp_ren;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
    logic        exp_dv;
    logic [31:0] exp_dpc0;
  } vec_t;

  vec_t vecs[13];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int n_req;
    int n_pops;

    //            rdy redir pc            ren a0            a1            dv dpc0
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       32'h14,       1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h18,       32'h1C,       1'b1, 32'h8};
    vecs[4]  = '{1'b1, 1'b1, 32'h103,      1'b0, 32'h20,       32'h24,       1'b1, 32'h10};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      32'h104,      1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h108,      32'h10C,      1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h110,      32'h114,      1'b1, 32'h100};
    vecs[8]  = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h118,     32'h11C,      1'b1, 32'h108};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        1'b1, 32'hFFFF_FFF8};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       32'h14,       1'b1, 32'h0};

    // ---- streaming, redirect with same-cycle response, wrap redirect ----
    do_reset();
    for (int i = 0; i < 13; i++) begin
      dec_ready      = vecs[i].dec_ready;
      redirect_valid = vecs[i].redir_v;
      redirect_pc    = vecs[i].redir_pc;
      #1;
      if (vecs[i].redir_v) check($sformatf("v%0d imem_valid at redirect", i), {31'b0, imem_valid}, 32'd1);
      check($sformatf("v%0d imem_ren", i), {31'b0, imem_ren}, {31'b0, vecs[i].exp_ren});
      check($sformatf("v%0d imem_addr0", i), imem_addr0, vecs[i].exp_a0);
      check($sformatf("v%0d imem_addr1", i), imem_addr1, vecs[i].exp_a1);
      check($sformatf("v%0d dec_valid", i), {31'b0, dec_valid}, {31'b0, vecs[i].exp_dv});
      if (vecs[i].exp_dv) check_head($sformatf("v%0d", i), vecs[i].exp_dpc0);
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    // ---- credit limit with decode stalled, then one-slot release ----
    do_reset();
    n_req = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (imem_ren) begin
        check("stall req addr", imem_addr0, 32'(n_req * 8));
        n_req++;
      end
      @(negedge clk);
    end
    check("stall req count", 32'(n_req), 32'd4);
    dec_ready = 1'b1;
    #1;
    check("full dec_valid", {31'b0, dec_valid}, 32'd1);
    check_head("full head", 32'h0);
    check("full imem_ren", {31'b0, imem_ren}, 32'd0);
    @(negedge clk);
    dec_ready = 1'b0;
    n_req = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (imem_ren) begin
        check("release req addr", imem_addr0, 32'd32);
        n_req++;
      end
      @(negedge clk);
    end
    check("release req count", 32'(n_req), 32'd1);

    // ---- drain while refilling: order, no loss, no duplication ----
    exp_q.delete();
    for (int k = 1; k <= 40; k++) exp_q.push_back(32'(k * 8));
    dec_ready = 1'b1;
    n_pops = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dec_valid) begin
        if (exp_q.size() == 0) begin
          check("drain queue underrun", 32'd0, 32'd1);
        end else begin
          check_head($sformatf("drain%0d", n_pops), exp_q.pop_front());
        end
        n_pops++;
      end
      @(negedge clk);
    end
    check("drain pop count", 32'(n_pops), 32'd20);
    dec_ready = 1'b0;

    // ---- reset with 3 queued + 1 in flight; stale response after release ----
    do_reset();
    repeat (4) @(negedge clk);
    #1;
    check("pre-reset dec_valid", {31'b0, dec_valid}, 32'd1);
    check("pre-reset imem_ren", {31'b0, imem_ren}, 32'd0);
    check("pre-reset imem_valid", {31'b0, imem_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("async reset dec_valid", {31'b0, dec_valid}, 32'd0);
    check("async reset imem_ren", {31'b0, imem_ren}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    force_valid = 1'b1;
    #1;
    check("post-reset imem_ren", {31'b0, imem_ren}, 32'd1);
    check("post-reset imem_addr0", imem_addr0, 32'h0);
    check("post-reset dec_valid", {31'b0, dec_valid}, 32'd0);
    @(negedge clk);
    force_valid = 1'b0;
    #1;
    check("stale ignored dec_valid", {31'b0, dec_valid}, 32'd0);
    check("second req addr", imem_addr0, 32'h8);
    @(negedge clk);
    #1;
    check("first pair dec_valid", {31'b0, dec_valid}, 32'd1);
    check_head("first pair", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
